// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park occupancy controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN_A     = 3'd1,
    IN_AB    = 3'd2,
    IN_B     = 3'd3,
    OUT_B    = 3'd4,
    OUT_BA   = 3'd5,
    OUT_A    = 3'd6,
    WAIT_CLR = 3'd7
  } lane_state_t;

  // ab encoding is {a_blk, b_blk}
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

  function automatic int cnt_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/lane_decoder.sv
// One gate lane: synchronise and debounce beams A/B, then decode the
// blocked pattern sequence into registered entry/exit/error pulses.
module lane_decoder
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter bit SENSOR_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic lane_err
);

  localparam logic IDLE_LVL = SENSOR_LOW;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    blk_s;
  logic [1:0]    deb_r;
  logic [DW-1:0] deb_cnt_r [2];
  lane_state_t   state_r;
  lane_state_t   state_s;
  logic          entry_s;
  logic          exit_s;
  logic          err_s;
  logic          entry_pulse_r;
  logic          exit_pulse_r;
  logic          lane_err_r;

  // two-flop synchroniser, idles at the not-blocked level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {2{IDLE_LVL}};
      sync2_r <= {2{IDLE_LVL}};
    end else begin
      sync1_r <= {sensor_a, sensor_b};
      sync2_r <= sync1_r;
    end
  end

  assign blk_s = SENSOR_LOW ? ~sync2_r : sync2_r;

  // per-beam debouncer: follow blk_s only after DEB_CYCLES differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (blk_s[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= blk_s[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // sequence decoder: forward, back one step, or fall into WAIT_CLR
  always_comb begin
    state_s = state_r;
    entry_s = 1'b0;
    exit_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: case (deb_r)
        AB_NONE: state_s = IDLE;
        AB_A:    state_s = IN_A;
        AB_B:    state_s = OUT_B;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      IN_A: case (deb_r)
        AB_A:    state_s = IN_A;
        AB_BOTH: state_s = IN_AB;
        AB_NONE: state_s = IDLE;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      IN_AB: case (deb_r)
        AB_BOTH: state_s = IN_AB;
        AB_B:    state_s = IN_B;
        AB_A:    state_s = IN_A;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      IN_B: case (deb_r)
        AB_B:    state_s = IN_B;
        AB_NONE: begin state_s = IDLE; entry_s = 1'b1; end
        AB_BOTH: state_s = IN_AB;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      OUT_B: case (deb_r)
        AB_B:    state_s = OUT_B;
        AB_BOTH: state_s = OUT_BA;
        AB_NONE: state_s = IDLE;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      OUT_BA: case (deb_r)
        AB_BOTH: state_s = OUT_BA;
        AB_A:    state_s = OUT_A;
        AB_B:    state_s = OUT_B;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      OUT_A: case (deb_r)
        AB_A:    state_s = OUT_A;
        AB_NONE: begin state_s = IDLE; exit_s = 1'b1; end
        AB_BOTH: state_s = OUT_BA;
        default: begin state_s = WAIT_CLR; err_s = 1'b1; end
      endcase
      WAIT_CLR: begin
        if (deb_r == AB_NONE) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_CLR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state and pulse registers; clr abandons any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      entry_pulse_r <= 1'b0;
      exit_pulse_r  <= 1'b0;
      lane_err_r    <= 1'b0;
    end else if (clr) begin
      state_r       <= IDLE;
      entry_pulse_r <= 1'b0;
      exit_pulse_r  <= 1'b0;
      lane_err_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      entry_pulse_r <= entry_s;
      exit_pulse_r  <= exit_s;
      lane_err_r    <= err_s;
    end
  end

  assign entry_pulse = entry_pulse_r;
  assign exit_pulse  = exit_pulse_r;
  assign lane_err    = lane_err_r;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane car-park occupancy controller: per-lane decoders feeding one
// shared saturating occupancy counter with registered status flags.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int N_LANES    = 2,
  parameter int CAPACITY   = 7,
  parameter int DEB_CYCLES = 16,
  parameter bit SENSOR_LOW = 1'b1,
  localparam int CNT_W     = cnt_width(CAPACITY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] sensor_a,
  input  logic [N_LANES-1:0] sensor_b,
  input  logic               clr,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   free_slots,
  output logic               full,
  output logic               empty,
  output logic [N_LANES-1:0] entry_pulse,
  output logic [N_LANES-1:0] exit_pulse,
  output logic [N_LANES-1:0] lane_err,
  output logic               sat_err
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic signed [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0]        next_s;
  logic                    sat_s;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        free_r;
  logic                    full_r;
  logic                    empty_r;
  logic                    sat_err_r;

  function automatic logic [SUM_W-1:0] popcount(input logic [N_LANES-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_LANES; i++) n = n + SUM_W'(v[i]);
    return n;
  endfunction

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_decoder #(
      .DEB_CYCLES (DEB_CYCLES),
      .SENSOR_LOW (SENSOR_LOW)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .sensor_a    (sensor_a[g]),
      .sensor_b    (sensor_b[g]),
      .entry_pulse (entry_pulse[g]),
      .exit_pulse  (exit_pulse[g]),
      .lane_err    (lane_err[g])
    );
  end

  // all lanes' pulses merge into one signed update, clamped to [0, CAPACITY]
  always_comb begin
    sum_s = $signed({2'b00, count_r}) + $signed(popcount(entry_pulse))
          - $signed(popcount(exit_pulse));
    if (sum_s[SUM_W-1]) begin
      next_s = '0;
      sat_s  = 1'b1;
    end else if (sum_s > CAP_S) begin
      next_s = CAP_C;
      sat_s  = 1'b1;
    end else begin
      next_s = sum_s[CNT_W-1:0];
      sat_s  = 1'b0;
    end
  end

  // occupancy and status flags update together; clr beats same-cycle events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= '0;
      free_r    <= CAP_C;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      sat_err_r <= 1'b0;
    end else if (clr) begin
      count_r   <= '0;
      free_r    <= CAP_C;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      sat_err_r <= 1'b0;
    end else begin
      count_r   <= next_s;
      free_r    <= CAP_C - next_s;
      full_r    <= (next_s == CAP_C);
      empty_r   <= (next_s == '0);
      sat_err_r <= sat_s;
    end
  end

  assign count      = count_r;
  assign free_slots = free_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign sat_err    = sat_err_r;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench: stimulus steps drive held A/B patterns and push expected
// pulses/occupancy from a path-index lane model; a monitor pops and compares.
module tb_parking_occupancy_ctrl;

  localparam int CAP  = 3;
  localparam int HOLD = 10;

  logic       clk;
  logic       rst_n;
  logic [1:0] sensor_a;
  logic [1:0] sensor_b;
  logic       clr;
  logic [1:0] count;
  logic [1:0] free_slots;
  logic       full;
  logic       empty;
  logic [1:0] entry_pulse;
  logic [1:0] exit_pulse;
  logic [1:0] lane_err;
  logic       sat_err;

  parking_occupancy_ctrl #(
    .N_LANES    (2),
    .CAPACITY   (CAP),
    .DEB_CYCLES (4),
    .SENSOR_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .clr         (clr),
    .count       (count),
    .free_slots  (free_slots),
    .full        (full),
    .empty       (empty),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .lane_err    (lane_err),
    .sat_err     (sat_err)
  );

  typedef struct packed {
    logic [1:0] ent;
    logic [1:0] ext;
    logic [1:0] err;
    logic [1:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: position along the entry or exit path per lane
  int   mp [2];
  int   mdir [2];
  bit   mwait [2];
  int   cnt_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [1:0] path_ab(input int d, input int idx);
    logic [1:0] ent_path [4];
    logic [1:0] ext_path [4];
    ent_path = '{2'b00, 2'b10, 2'b11, 2'b01};
    ext_path = '{2'b00, 2'b01, 2'b11, 2'b10};
    if (idx < 0 || idx > 3) return 2'bxx;
    return (d == 0) ? ent_path[idx] : ext_path[idx];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      mp[l] = 0; mdir[l] = 0; mwait[l] = 1'b0;
    end
  endtask

  task automatic model_lane(input int l, input logic [1:0] ab,
                            output bit ev_ent, output bit ev_ext, output bit ev_err);
    ev_ent = 1'b0; ev_ext = 1'b0; ev_err = 1'b0;
    if (mwait[l]) begin
      if (ab == 2'b00) mwait[l] = 1'b0;
    end else if (mp[l] == 0) begin
      if (ab == 2'b10) begin mdir[l] = 0; mp[l] = 1; end
      else if (ab == 2'b01) begin mdir[l] = 1; mp[l] = 1; end
      else if (ab == 2'b11) begin ev_err = 1'b1; mwait[l] = 1'b1; end
    end else if (ab === path_ab(mdir[l], mp[l])) begin
      // held: no movement
    end else if (mp[l] == 3 && ab == 2'b00) begin
      if (mdir[l] == 0) ev_ent = 1'b1; else ev_ext = 1'b1;
      mp[l] = 0;
    end else if (mp[l] < 3 && ab === path_ab(mdir[l], mp[l] + 1)) begin
      mp[l] = mp[l] + 1;
    end else if (ab === path_ab(mdir[l], mp[l] - 1)) begin
      mp[l] = mp[l] - 1;
    end else begin
      ev_err = 1'b1; mwait[l] = 1'b1; mp[l] = 0;
    end
  endtask

  task automatic do_step(input logic [3:0] abv, input bit use_clr);
    logic [1:0] ab [2];
    exp_t e;
    bit   eo, xo, ro, seen;
    int   sum;
    bit   sat;
    ab[0] = abv[3:2];
    ab[1] = abv[1:0];
    e = '0;
    sum = cnt_m;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      sensor_a[l] = ~ab[l][1];
      sensor_b[l] = ~ab[l][0];
      model_lane(l, ab[l], eo, xo, ro);
      e.ent[l] = eo; e.ext[l] = xo; e.err[l] = ro;
      if (eo) sum++;
      if (xo) sum--;
    end
    sat = 1'b0;
    if (sum < 0) begin sum = 0; sat = 1'b1; end
    else if (sum > CAP) begin sum = CAP; sat = 1'b1; end
    if (use_clr) begin
      sum = 0; sat = 1'b0; model_reset();
    end
    cnt_m = sum;
    e.cnt = 2'(sum);
    e.sat = sat;
    if (|{e.ent, e.ext, e.err}) exp_q.push_back(e);
    if (use_clr) begin
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (entry_pulse[0]) begin seen = 1'b1; break; end
      end
      if (!seen) chk("clr_wait_entry_pulse", 0, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    repeat (HOLD) @(negedge clk);
  endtask

  function automatic logic [1:0] pick_ab(input int l);
    if (mwait[l]) return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 7) begin
      if (mp[l] == 0) return ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      if (mp[l] == 3) return 2'b00;
      return path_ab(mdir[l], mp[l] + 1);
    end
    return 2'($urandom_range(0, 3));
  endfunction

  // monitor: pop an expectation on every pulse, check occupancy one cycle later
  bit   status_due = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      status_due = 1'b0;
    end else begin
      if (status_due) begin
        chk("count", count, cur.cnt);
        chk("free_slots", free_slots, CAP - cur.cnt);
        chk("full", full, cur.cnt == CAP);
        chk("empty", empty, cur.cnt == 0);
        chk("sat_err", sat_err, cur.sat);
        status_due = 1'b0;
      end else if (sat_err) begin
        chk("sat_err_unexpected", sat_err, 0);
      end
      if (|{entry_pulse, exit_pulse, lane_err}) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulses", {entry_pulse, exit_pulse, lane_err}, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("entry_pulse", entry_pulse, cur.ent);
          chk("exit_pulse", exit_pulse, cur.ext);
          chk("lane_err", lane_err, cur.err);
          status_due = 1'b1;
        end
      end
    end
  end

  logic [3:0] dir_tab [] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0000,   // lane0 entry -> 1
    4'b0010, 4'b0011, 4'b0001, 4'b0000,   // lane1 entry -> 2
    4'b0001, 4'b0011, 4'b0010, 4'b0000,   // lane1 exit -> 1
    4'b0100, 4'b1100, 4'b1000, 4'b0000,   // lane0 exit -> 0
    4'b0100, 4'b1100, 4'b1000, 4'b0000,   // lane0 exit at empty -> sat
    4'b1000, 4'b1100, 4'b0100, 4'b0000,   // lane0 entry -> 1
    4'b1001, 4'b1111, 4'b0110, 4'b0000,   // entry + exit together -> 1
    4'b0010, 4'b0011, 4'b0001, 4'b0000,   // lane1 entry -> 2
    4'b1010, 4'b1111, 4'b0101, 4'b0000,   // both enter -> 3, sat, full
    4'b1000, 4'b0100, 4'b1100, 4'b0000,   // 10->01 error, wait, release
    4'b1000, 4'b1100, 4'b1000, 4'b0000    // back-out, no event
  };

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    sensor_a = 2'b11;
    sensor_b = 2'b11;
    model_reset();
    cnt_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_free_slots", free_slots, CAP);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {entry_pulse, exit_pulse, lane_err, sat_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (dir_tab[i]) do_step(dir_tab[i], 1'b0);

    // short blocked glitches on A must be filtered
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      sensor_a[0] = 1'b0;
      repeat (2) @(negedge clk);
      sensor_a[0] = 1'b1;
      repeat (12) @(negedge clk);
    end
    chk("glitch_count", count, cnt_m);

    // async reset in the middle of an entry (IN_AB)
    do_step(4'b1000, 1'b0);
    do_step(4'b1100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sensor_a = 2'b11;
    sensor_b = 2'b11;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_free_slots", free_slots, CAP);
    chk("midrst_pulses", {entry_pulse, exit_pulse, lane_err}, 0);
    model_reset();
    cnt_m = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_quiet_count", count, 0);

    // fresh entry proves the lane is idle, then clr collides with an entry pulse
    foreach (dir_tab[i]) if (i < 4) do_step(dir_tab[i], 1'b0);
    do_step(4'b1000, 1'b0);
    do_step(4'b1100, 1'b0);
    do_step(4'b0100, 1'b0);
    do_step(4'b0000, 1'b1);
    chk("clr_count", count, 0);

    for (int r = 0; r < 200; r++) do_step({pick_ab(0), pick_ab(1)}, 1'b0);

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
